// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with single-cycle ops and an optional iterative multiplier.
// Define ALU_PIPE_MUL_EN to build the shift-add MUL datapath and BUSY state; otherwise MUL is an illegal ADD.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND = 4'b0010, OP_SLL = 4'b0011,
        OP_OR   = 4'b0100, OP_XOR  = 4'b0101, OP_SRL = 4'b0110, OP_SRA = 4'b0111,
        OP_SLT  = 4'b1000, OP_SLTU = 4'b1001, OP_MUL = 4'b1010
    } op_e;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             negative;
        logic             carry;
        logic             overflow;
        logic             illegal;
    } out_t;

    function automatic out_t make_out(input logic [WIDTH-1:0] r, input logic c,
                                      input logic v, input logic ill);
        out_t o;
        o.result   = r;
        o.zero     = (r == '0);
        o.negative = r[WIDTH-1];
        o.carry    = c;
        o.overflow = v;
        o.illegal  = ill;
        return o;
    endfunction

    state_e           state_q, state_d;
    out_t             out_q, out_d, alu_out;
    logic             out_valid_q, out_valid_d;
    logic             accept;
    logic [WIDTH:0]   add_w, sub_w;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_ill;

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} - {1'b0, b};
    assign shamt = b[SHW-1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD: begin
                alu_c = add_w[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: begin
                // Undefined codes (and MUL when not built) run as ADD and are flagged.
                alu_c   = add_w[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
                alu_ill = 1'b1;
            end
        endcase
        alu_out = make_out(alu_res, alu_c, alu_v, alu_ill);
    end

`ifdef ALU_PIPE_MUL_EN
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
`ifdef ALU_PIPE_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        if ((state_q == DONE) && out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end
`ifdef ALU_PIPE_MUL_EN
        if (state_q == BUSY) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_step;
            cnt_d    = cnt_q + SHW'(1);
            if (cnt_q == SHW'(WIDTH - 1)) begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                out_d       = make_out(acc_step[WIDTH-1:0], |acc_step[2*WIDTH-1:WIDTH], 1'b0, 1'b0);
            end
        end
`endif
        if (accept) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_d       = alu_out;
`ifdef ALU_PIPE_MUL_EN
            if (op == OP_MUL) begin
                state_d     = BUSY;
                out_valid_d = 1'b0;
                out_d       = out_q;
                mcand_d     = {{WIDTH{1'b0}}, a};
                mplier_d    = b;
                acc_d       = '0;
                cnt_d       = '0;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
`ifdef ALU_PIPE_MUL_EN
        // NOTE: multiplier working registers are not reset; they are always loaded on accept before use.
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
        cnt_q    <= cnt_d;
`endif
    end

    assign out_valid = out_valid_q;
    assign result    = out_q.result;
    assign zero      = out_q.zero;
    assign negative  = out_q.negative;
    assign carry     = out_q.carry;
    assign overflow  = out_q.overflow;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes model results, monitor pops on each presented result.
module tb_alu_pipe;

    localparam int W = 16;
`ifdef ALU_PIPE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd3, OP_SRA = 4'd7,
                           OP_MUL = 4'd10, OP_BAD = 4'd15;

    logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, result;
    logic [3:0]   op;
    logic         zero, negative, carry, overflow, illegal;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .negative(negative), .carry(carry),
        .overflow(overflow), .illegal(illegal)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   flags;   // {zero, negative, carry, overflow, illegal}
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   pres_cyc[$];
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   rdy_pct;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain wide-integer arithmetic on the operation rules.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input int acc_at);
        exp_t   e;
        longint ux, uy, sx, sy, full, m, s;
        int     sh;
        bit     c, v, ill;
        logic [3:0] oe;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        m  = longint'(1) << W;
        sh = int'(uy % W);
        c = 1'b0; v = 1'b0; ill = 1'b0; full = 0;
        oe = o;
        if (o > 4'd10 || (o == 4'd10 && !MUL_EN)) begin
            ill = 1'b1;
            oe  = OP_ADD;
        end
        case (oe)
            4'd0: begin full = ux + uy; c = (full >= m); s = sx + sy; v = (s >= m / 2) || (s < -(m / 2)); end
            4'd1: begin full = ux - uy; c = (ux < uy); s = sx - sy; v = (s >= m / 2) || (s < -(m / 2)); end
            4'd2: full = ux & uy;
            4'd3: full = ux << sh;
            4'd4: full = ux | uy;
            4'd5: full = ux ^ uy;
            4'd6: full = ux >> sh;
            4'd7: full = sx >>> sh;
            4'd8: full = (sx < sy) ? 1 : 0;
            4'd9: full = (ux < uy) ? 1 : 0;
            default: begin full = ux * uy; c = (full >= m); end
        endcase
        e.res   = full[W-1:0];
        e.flags = {(e.res == '0), e.res[W-1], c, v, ill};
        e.lat   = (oe == OP_MUL) ? W + 1 : 1;
        e.acc   = acc_at;
        return e;
    endfunction

    task automatic step(input bit v, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit r, output bit accepted);
        @(negedge clk);
        in_valid  = v;
        op        = o;
        a         = x;
        b         = y;
        out_ready = r;
        #1;
        accepted = v && in_ready;
        if (accepted) sb.push_back(model(o, x, y, cyc + 1));
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++)
            step(1'b1, o, x, y, (int'($urandom_range(99)) < rdy_pct), acc);
        if (!acc) check("accept_timeout", 64'(acc), 64'(1));
    endtask

    task automatic idle(input int n, input bit r);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b0, OP_ADD, '0, '0, r, acc);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: one scoreboard pop per newly presented result; held results re-checked every cycle.
    initial begin
        exp_t cur;
        bit   holding, have_cur;
        holding  = 1'b0;
        have_cur = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                holding  = 1'b0;
                have_cur = 1'b0;
            end else begin
                if (holding && !out_valid) check("valid_dropped", 64'(out_valid), 64'(1));
                if (out_valid && !holding) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", 64'(out_valid), 64'(0));
                        have_cur = 1'b0;
                    end else begin
                        cur      = sb.pop_front();
                        have_cur = 1'b1;
                        pres_cyc.push_back(cyc);
                        check("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
                    end
                end
                if (out_valid && have_cur) begin
                    check("result", 64'(result), 64'(cur.res));
                    check("flags", 64'({zero, negative, carry, overflow, illegal}), 64'(cur.flags));
                end
                holding = out_valid && !out_ready;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1);
    end

    initial begin
        bit acc;
        n_checks = 0; n_fail = 0; cyc = 0; rdy_pct = 100;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_result", 64'(result), 64'(0));
        check("reset_flags", 64'({zero, negative, carry, overflow, illegal}), 64'(0));
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(1));

        issue(OP_ADD, 16'hFFFF, 16'h0001);
        issue(OP_SUB, 16'h8000, 16'h0001);
        issue(OP_SRA, 16'h8000, 16'h0013);
        issue(OP_SLL, 16'h8000, 16'h0013);
        issue(OP_BAD, 16'h1234, 16'h1111);
        idle(2, 1'b1);

        issue(OP_MUL, 16'h0100, 16'h0101);
`ifdef ALU_PIPE_MUL_EN
        for (int k = 0; k < W; k++) begin
            step(1'b1, OP_ADD, 16'h0001, 16'h0001, 1'b1, acc);
            check("busy_in_ready", 64'(in_ready), 64'(0));
        end
`else
        step(1'b1, OP_ADD, 16'h0001, 16'h0001, 1'b1, acc);
        check("done_in_ready", 64'(in_ready), 64'(1));
`endif
        idle(3, 1'b1);

        // Hold a result for five cycles, then stream four ADDs with no bubble.
        rdy_pct = 0;
        issue(OP_ADD, 16'h7FFF, 16'h0001);
        for (int k = 0; k < 5; k++) begin
            idle(1, 1'b0);
            check("hold_in_ready", 64'(in_ready), 64'(0));
        end
        pres_cyc.delete();
        rdy_pct = 100;
        for (int k = 0; k < 4; k++) issue(OP_ADD, pick(), pick());
        idle(3, 1'b1);
        check("stream_count", 64'(pres_cyc.size()), 64'(4));
        for (int k = 1; k < pres_cyc.size(); k++)
            check("stream_gap", 64'(pres_cyc[k] - pres_cyc[k-1]), 64'(1));

        // Reset in the middle of a multiply: nothing may ever come out.
        issue(OP_MUL, 16'h00FF, 16'h00FF);
        idle(5, 1'b1);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'(1));
        check("abort_result", 64'(result), 64'(0));
        for (int k = 0; k < W + 4; k++) begin
            idle(1, 1'b1);
            check("abort_out_valid", 64'(out_valid), 64'(0));
        end

        rdy_pct = 70;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3) == 0) idle(int'($urandom_range(2)), 1'($urandom_range(1)));
            issue(4'($urandom_range(15)), pick(), pick());
        end

        rdy_pct = 100;
        for (int k = 0; k < 300 && sb.size() > 0; k++) idle(1, 1'b1);
        idle(2, 1'b1);
        check("drain_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, datapath width in bits (power of two, 8..64).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block accepts an operation this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B; shifts use b[SHW-1:0] only.
REQ-009 op  input  4  operation code.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 zero / negative / carry / overflow  output  1 each  status flags.
REQ-014 illegal  output  1  accepted op code was undefined or compiled out.

Function
REQ-015 Op codes SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 SLL, 0100 OR, 0101 XOR, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 MUL; all other codes SHALL execute ADD with illegal=1.
REQ-016 The transfer SHALL occur when in_valid && in_ready on a rising edge; a, b, op are captured then and may change afterwards.
REQ-017 The FSM SHALL have states IDLE, BUSY, DONE; reset state IDLE.
REQ-018 in_ready SHALL be 1 in IDLE, 0 in BUSY, and equal out_ready in DONE.
REQ-019 Non-MUL ops: IDLE/DONE -> DONE on accept; out_valid SHALL rise on the cycle after the accept (latency 1).
REQ-020 MUL: accept -> BUSY; unsigned shift-add, one bit of b per cycle, WIDTH cycles in BUSY, then DONE (latency WIDTH+1).
REQ-021 In DONE, result/flags SHALL hold stable until out_valid && out_ready; with no new accept the FSM then goes to IDLE and out_valid drops.
REQ-022 Simultaneous result take and new accept in DONE SHALL produce back-to-back results with no bubble (one result per cycle).
REQ-023 SLT/SLTU SHALL return 1 or 0 zero-extended to WIDTH (signed/unsigned a<b).
REQ-024 SRA SHALL replicate a[WIDTH-1]; shift amount 0 returns a unchanged.
REQ-025 ADD: carry = carry-out of bit WIDTH-1; SUB: carry = borrow (a<b unsigned); overflow = two's-complement overflow for ADD/SUB only.
REQ-026 MUL: result = low WIDTH bits of product; carry = 1 if high WIDTH bits nonzero; overflow=0.
REQ-027 All other ops: carry=0, overflow=0.
REQ-028 zero SHALL equal (result==0); negative SHALL equal result[WIDTH-1]; all flags registered with result.

Reset
REQ-029 While rst_n=0 at a clock edge: FSM -> IDLE; out_valid, result, all flags, illegal SHALL be 0; in_ready SHALL be 1 from the first cycle after reset.
REQ-030 Reset during BUSY or DONE SHALL abort the operation with no result ever delivered.

Configuration
REQ-031 Macro ALU_PIPE_MUL_EN SHALL compile in the MUL datapath and BUSY state.
REQ-032 Without ALU_PIPE_MUL_EN, op 1010 SHALL complete in 1 cycle as ADD with illegal=1; BUSY is unreachable.

Verification
REQ-033 WIDTH=16: ADD a=0xFFFF b=0x0001 -> result 0x0000, zero=1, carry=1, overflow=0, 1 cycle latency.
REQ-034 SUB a=0x8000 b=0x0001 -> result 0x7FFF, overflow=1, carry=0, negative=0.
REQ-035 SRA a=0x8000 b=0x0013 (amount 3) -> 0xF000; SLL same operands -> 0x0000, zero=1.
REQ-036 MUL_EN set: MUL a=0x0100 b=0x0101 -> out_valid exactly 17 cycles after accept, result 0x0100, carry=1; in_ready=0 throughout BUSY.
REQ-037 out_ready=0 for 5 cycles after a result: result held stable, in_ready=0; then out_ready=1 with in_valid=1 streaming 4 ADDs -> 4 results on 4 consecutive cycles.
REQ-038 op=1111 -> ADD result, illegal=1; rst_n=0 mid-MUL -> out_valid stays 0, in_ready=1 after reset.
